add_round_key_stage: RTL

Versat functional unit that sits directly downstream of MixColumns in the AES round datapath. It XORs the 16-byte state (in0..in15, one byte per lane) with a round key from an internal memory-mapped key store. A round counter advances on each accepted state, so one run processes a configurable sequence of rounds. It registers the result and flags completion.

---
 rtl/add_round_key_stage_if.sv | 25 ++
 rtl/add_round_key_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stage_if.sv
// Memory-mapped key-store access bus for add_round_key_stage.
// The master drives a request (valid/addr/wstrb/wdata). The slave answers one
// cycle later with ready/rdata. rdata is zero whenever ready is low, so several
// slaves can share a read bus through an OR.
interface add_round_key_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     wdata;
   logic                  ready;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output valid, addr, wstrb, wdata,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wstrb, wdata,
      output ready, rdata
   );
endinterface

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage. It XORs a 16-byte state with a round key taken from an
// internal memory-mapped key store, and it steps a round counter once per
// accepted state.
// Optional feature macro: ADD_ROUND_KEY_REVERSE_EN. It adds a 'reverse' input.
// When reverse is high at run, the round counter counts down, which gives
// decryption key order.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for run; in_valid is ignored and outputs hold
// BUSY  | one state is accepted per in_valid; the run ends at last_round
module add_round_key_stage #(
   parameter int DATA_W     = 32,
   parameter int NUM_ROUNDS = 15,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
`ifdef ADD_ROUND_KEY_REVERSE_EN
   input  logic              reverse,
`endif
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [DATA_W-1:0] in10,
   input  logic [DATA_W-1:0] in11,
   input  logic [DATA_W-1:0] in12,
   input  logic [DATA_W-1:0] in13,
   input  logic [DATA_W-1:0] in14,
   input  logic [DATA_W-1:0] in15,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic [DATA_W-1:0] out8,
   output logic [DATA_W-1:0] out9,
   output logic [DATA_W-1:0] out10,
   output logic [DATA_W-1:0] out11,
   output logic [DATA_W-1:0] out12,
   output logic [DATA_W-1:0] out13,
   output logic [DATA_W-1:0] out14,
   output logic [DATA_W-1:0] out15,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   input  logic [3:0]        AddRoundKey_start_round,
   input  logic [3:0]        AddRoundKey_last_round,
   add_round_key_stage_if.slave bus
);

   localparam int NUM_WORDS = 4 * NUM_ROUNDS;
   localparam int KIDX_W    = $clog2(NUM_WORDS);
   localparam int WORD_W    = ADDR_W - 2;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [3:0]        round;
   logic [3:0]        round_next;
   logic [DATA_W-1:0] key_mem  [NUM_WORDS];
   logic [DATA_W-1:0] rd_word  [4];
   logic [7:0]        key_byte [16];
   logic [7:0]        in_byte  [16];
   logic [7:0]        out_byte [16];

   logic [WORD_W-1:0] bus_word;
   logic [KIDX_W-1:0] bus_idx;
   logic              bus_hit;
   logic              bus_wr;

`ifdef ADD_ROUND_KEY_REVERSE_EN
   logic              rev_q;
   assign round_next = rev_q ? round - 4'd1 : round + 4'd1;
`else
   assign round_next = round + 4'd1;
`endif

   // Only the low byte of each lane carries state.
   assign in_byte[0]  = in0[7:0];
   assign in_byte[1]  = in1[7:0];
   assign in_byte[2]  = in2[7:0];
   assign in_byte[3]  = in3[7:0];
   assign in_byte[4]  = in4[7:0];
   assign in_byte[5]  = in5[7:0];
   assign in_byte[6]  = in6[7:0];
   assign in_byte[7]  = in7[7:0];
   assign in_byte[8]  = in8[7:0];
   assign in_byte[9]  = in9[7:0];
   assign in_byte[10] = in10[7:0];
   assign in_byte[11] = in11[7:0];
   assign in_byte[12] = in12[7:0];
   assign in_byte[13] = in13[7:0];
   assign in_byte[14] = in14[7:0];
   assign in_byte[15] = in15[7:0];

   assign out0  = {{(DATA_W-8){1'b0}}, out_byte[0]};
   assign out1  = {{(DATA_W-8){1'b0}}, out_byte[1]};
   assign out2  = {{(DATA_W-8){1'b0}}, out_byte[2]};
   assign out3  = {{(DATA_W-8){1'b0}}, out_byte[3]};
   assign out4  = {{(DATA_W-8){1'b0}}, out_byte[4]};
   assign out5  = {{(DATA_W-8){1'b0}}, out_byte[5]};
   assign out6  = {{(DATA_W-8){1'b0}}, out_byte[6]};
   assign out7  = {{(DATA_W-8){1'b0}}, out_byte[7]};
   assign out8  = {{(DATA_W-8){1'b0}}, out_byte[8]};
   assign out9  = {{(DATA_W-8){1'b0}}, out_byte[9]};
   assign out10 = {{(DATA_W-8){1'b0}}, out_byte[10]};
   assign out11 = {{(DATA_W-8){1'b0}}, out_byte[11]};
   assign out12 = {{(DATA_W-8){1'b0}}, out_byte[12]};
   assign out13 = {{(DATA_W-8){1'b0}}, out_byte[13]};
   assign out14 = {{(DATA_W-8){1'b0}}, out_byte[14]};
   assign out15 = {{(DATA_W-8){1'b0}}, out_byte[15]};

   // The byte-lane upper bits and the byte offset of addr carry no information.
   logic unused_bits;
   assign unused_bits = ^{bus.addr[1:0],
                          in0[DATA_W-1:8],  in1[DATA_W-1:8],  in2[DATA_W-1:8],  in3[DATA_W-1:8],
                          in4[DATA_W-1:8],  in5[DATA_W-1:8],  in6[DATA_W-1:8],  in7[DATA_W-1:8],
                          in8[DATA_W-1:8],  in9[DATA_W-1:8],  in10[DATA_W-1:8], in11[DATA_W-1:8],
                          in12[DATA_W-1:8], in13[DATA_W-1:8], in14[DATA_W-1:8], in15[DATA_W-1:8]};

   // Bus decode. Out-of-range words are still acknowledged, but they are never stored.
   assign bus_word = bus.addr[ADDR_W-1:2];
   assign bus_hit  = 32'(bus_word) < NUM_WORDS;
   assign bus_idx  = KIDX_W'(bus_word);
   assign bus_wr   = |bus.wstrb;

   // Select the four key words of the current round. Rounds past the store read as zero.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         rd_word[j] = '0;
         if (32'(round) < NUM_ROUNDS)
            rd_word[j] = key_mem[KIDX_W'(32'(round) * 4 + j)];
      end
      for (int k = 0; k < 16; k++)
         key_byte[k] = rd_word[k/4][8*(k%4) +: 8];
   end

   // Key store with a byte-strobed write port. A read in the same cycle sees the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NUM_WORDS; w++)
            key_mem[w] <= '0;
      end else if (bus.valid && bus_wr && bus_hit) begin
         for (int b = 0; b < DATA_W/8; b++)
            if (bus.wstrb[b])
               key_mem[bus_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
   end

   // Bus response: one-cycle acknowledge carrying the word as it was at request time.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ready <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ready <= bus.valid;
         bus.rdata <= (bus.valid && bus_hit) ? key_mem[bus_idx] : '0;
      end
   end

   // Round sequencing FSM with registered data and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         round     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
`ifdef ADD_ROUND_KEY_REVERSE_EN
         rev_q     <= 1'b0;
`endif
         for (int k = 0; k < 16; k++)
            out_byte[k] <= '0;
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  round <= AddRoundKey_start_round;
`ifdef ADD_ROUND_KEY_REVERSE_EN
                  rev_q <= reverse;
`endif
                  state <= BUSY;
                  busy  <= 1'b1;
               end
            end
            BUSY: begin
               if (run) begin
                  // A restart reloads the counter, and it drops any state offered in the same cycle.
                  round <= AddRoundKey_start_round;
`ifdef ADD_ROUND_KEY_REVERSE_EN
                  rev_q <= reverse;
`endif
               end else if (in_valid) begin
                  for (int k = 0; k < 16; k++)
                     out_byte[k] <= in_byte[k] ^ key_byte[k];
                  out_valid <= 1'b1;
                  if (round == AddRoundKey_last_round) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     round <= round_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
